// File: rtl/div_unit.sv
// div_unit
//   Sequential signed 32-bit divider (MIPS DIV). The quotient goes to lo and
//   the remainder to hi; both feed the MFHI/MFLO write-data select. It uses
//   restoring division on operand magnitudes, one quotient bit per cycle, and
//   applies a sign fix-up in a final cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   request a division (sampled only in IDLE)
//   a        in   [31:0] dividend (rs), two's complement
//   b        in   [31:0] divisor  (rt), two's complement
//   hi       out  [31:0] remainder, held until the next successful division
//   lo       out  [31:0] quotient,  held until the next successful division
//   busy     out  high while in CALC or FIX
//   done     out  one-cycle pulse when hi/lo have just been updated
//   div_zero out  one-cycle pulse when start was seen with b == 0
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] bmag;
    logic [31:0] rem;
    logic [31:0] q;
    logic [4:0]  count;
    logic        qs;
    logic        rs;

    // Magnitudes are 32-bit unsigned, so |0x80000000| stays 0x80000000.
    logic [31:0] amag_in;
    logic [31:0] bmag_in;
    assign amag_in = a[31] ? (~a + 32'd1) : a;
    assign bmag_in = b[31] ? (~b + 32'd1) : b;

    // One restoring step. rem < bmag <= 2^31 always holds, so the shifted
    // remainder fits in 32 bits. The 33-bit trial makes its sign a borrow flag.
    logic [31:0] rem_sh;
    logic [31:0] q_sh;
    logic [32:0] trial;
    assign rem_sh = {rem[30:0], q[31]};
    assign q_sh   = {q[30:0], 1'b0};
    assign trial  = {1'b0, rem_sh} - {1'b0, bmag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bmag     <= '0;
            rem      <= '0;
            q        <= '0;
            count    <= '0;
            qs       <= 1'b0;
            rs       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            div_zero <= 1'b1;
                        end else begin
                            bmag  <= bmag_in;
                            q     <= amag_in;
                            rem   <= '0;
                            count <= '0;
                            qs    <= a[31] ^ b[31];
                            rs    <= a[31];
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        q   <= {q_sh[31:1], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        q   <= q_sh;
                    end
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= qs ? (~q + 32'd1) : q;
                    hi    <= rs ? (~rem + 32'd1) : rem;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit
//   Self-checking bench for div_unit: table-driven signed divisions with
//   hand-computed results, plus directed sequences for divide-by-zero,
//   start-while-busy and reset during a division.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int unsigned checks;
    int unsigned failures;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one division and checks latency, busy width, done pulse and result.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int unsigned lat;
        int unsigned busy_cnt;
        bit          seen;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        busy_cnt = busy ? 1 : 0;
        seen = 1'b0;
        lat  = 0;
        for (int unsigned i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, 32'd33);
        check("busy_cycles", busy_cnt, 32'd33);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("lo", lo, exp_lo);
        check("hi", hi, exp_hi);
        @(posedge clk);
        #1;
        check("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        reset    = 1'b1;

        vecs[0] = '{32'd7,        32'd2,        32'd3,        32'd1};
        vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[3] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[5] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
        vecs[6] = '{32'd5,        32'd9,        32'd0,        32'd5};
        vecs[7] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};
        vecs[8] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
        vecs[9] = '{32'd100,      32'd7,        32'd14,       32'd2};

        // Reset state
        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_divz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int unsigned i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
        end

        // Divide by zero after 100/7 left lo=14, hi=2
        @(negedge clk);
        a     = 32'd55;
        b     = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        check("dz_busy", {31'd0, busy}, 32'd0);
        check("dz_done", {31'd0, done}, 32'd0);
        check("dz_hi", hi, 32'd2);
        check("dz_lo", lo, 32'd14);
        @(posedge clk);
        #1;
        check("dz_flag_width", {31'd0, div_zero}, 32'd0);
        check("dz_done2", {31'd0, done}, 32'd0);
        check("dz_busy2", {31'd0, busy}, 32'd0);

        // Start while busy is ignored
        begin
            int unsigned ndone;
            ndone = 0;
            @(negedge clk);
            a     = 32'd100;
            b     = 32'd7;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int unsigned i = 1; i <= 40; i++) begin
                if (i == 10) begin
                    a     = 32'd1;
                    b     = 32'd1;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                if (done) ndone++;
            end
            start = 1'b0;
            check("swb_done_count", ndone, 32'd1);
            check("swb_lo", lo, 32'd14);
            check("swb_hi", hi, 32'd2);
            check("swb_busy", {31'd0, busy}, 32'd0);
        end

        // Reset mid-division
        @(negedge clk);
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_divz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_div(32'd9, 32'd3, 32'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
